// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two requesters.
// One operation is captured, executed and returned every three cycles.

module alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic [WIDTH-1:0] o,
    output logic             cout
);

    // 00 add, 01 subtract (cout = borrow), 10 and, 11 or
    always_comb begin
        o    = '0;
        cout = 1'b0;
        unique case (op)
            2'b00:   {cout, o} = {1'b0, i0} + {1'b0, i1};
            2'b01:   {cout, o} = {1'b0, i0} - {1'b0, i1};
            2'b10:   o = i0 & i1;
            default: o = i0 | i1;
        endcase
    end

endmodule

module alu_arbiter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             busy
);

    localparam int unsigned OP_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              carry_q, carry_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              busy_q, busy_d;
    logic              win_c;
    logic [WIDTH-1:0]  alu_o;
    logic              alu_cout;

    // Contention goes to the requester that did not win last time
    assign win_c = (req0 && req1) ? !last_q : req1;

    alu #(.WIDTH(WIDTH)) u_alu (
        .op   (op_q),
        .i0   (a_q),
        .i1   (b_q),
        .o    (alu_o),
        .cout (alu_cout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req0 || req1) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d  = owner_q;
        last_d   = last_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        busy_d   = (state_d != IDLE);
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = win_c;
                    op_d    = win_c ? op1 : op0;
                    a_d     = win_c ? a1 : a0;
                    b_d     = win_c ? b1 : b0;
                    gnt0_d  = !win_c;
                    gnt1_d  = win_c;
                end
            end
            EXEC: begin
                result_d = alu_o;
                carry_d  = alu_cout;
                done0_d  = !owner_q;
                done1_d  = owner_q;
                last_d   = owner_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            last_q   <= last_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign result = result_q;
    assign carry  = carry_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter against a transaction-level
// model: winner from pending requests and last owner, result = a + b.

module tb_alu_arbiter;

    localparam int unsigned W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           req0, req1;
    logic [1:0]     op0, op1;
    logic [W-1:0]   a0, a1, b0, b1;
    logic           gnt0, gnt1, done0, done1, carry, busy;
    logic [W-1:0]   result;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    logic           pend [2];
    logic [W-1:0]   av [2];
    logic [W-1:0]   bv [2];
    logic [1:0]     opv [2];
    int             model_last;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .op0    (op0),
        .op1    (op1),
        .a0     (a0),
        .a1     (a1),
        .b0     (b0),
        .b1     (b1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .done0  (done0),
        .done1  (done1),
        .result (result),
        .carry  (carry),
        .busy   (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        req0 = pend[0];
        req1 = pend[1];
        op0  = opv[0];
        op1  = opv[1];
        a0   = av[0];
        a1   = av[1];
        b0   = bv[0];
        b1   = bv[1];
    endtask

    task automatic chk(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, "gnt0",   32'(gnt0),   32'(0));
        chk(tag, "gnt1",   32'(gnt1),   32'(0));
        chk(tag, "done0",  32'(done0),  32'(0));
        chk(tag, "done1",  32'(done1),  32'(0));
        chk(tag, "busy",   32'(busy),   32'(0));
    endtask

    // Present the pending requests in IDLE and follow one operation to completion.
    // With rereq the winner keeps requesting with the same operands.
    task automatic run_xact(input bit rereq, input string tag);
        int           w;
        logic [W:0]   exp_sum;
        drive();
        if (pend[0] && pend[1]) w = (model_last == 0) ? 1 : 0;
        else                    w = pend[1] ? 1 : 0;
        exp_sum = {1'b0, av[w]} + {1'b0, bv[w]};
        tick();
        chk(tag, "gnt0",  32'(gnt0),  32'(w == 0));
        chk(tag, "gnt1",  32'(gnt1),  32'(w == 1));
        chk(tag, "busy",  32'(busy),  32'(1));
        chk(tag, "done_g", 32'({done0, done1}), 32'(0));
        if (!rereq) begin
            pend[w] = 1'b0;
            av[w]   = 16'h1234;
            bv[w]   = W'($urandom);
            opv[w]  = 2'($urandom);
            drive();
        end
        tick();
        chk(tag, "done0",  32'(done0),  32'(w == 0));
        chk(tag, "done1",  32'(done1),  32'(w == 1));
        chk(tag, "gnt_d",  32'({gnt0, gnt1}), 32'(0));
        chk(tag, "result", 32'(result), 32'(exp_sum[W-1:0]));
        chk(tag, "carry",  32'(carry),  32'(exp_sum[W]));
        model_last = w;
        tick();
        chk(tag, "idle_busy", 32'(busy), 32'(0));
        chk(tag, "idle_done", 32'({done0, done1}), 32'(0));
        chk(tag, "idle_res",  32'(result), 32'(exp_sum[W-1:0]));
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0;
            av[p]   = '0;
            bv[p]   = '0;
            opv[p]  = 2'b00;
        end
        model_last = 1;

        // Reset held with req0 high: everything quiet
        reset   = 1'b0;
        pend[0] = 1'b1;
        av[0]   = 16'hf001;
        bv[0]   = 16'h0001;
        drive();
        repeat (3) tick();
        chk_quiet("reset");
        chk("reset", "result", 32'(result), 32'(0));
        chk("reset", "carry",  32'(carry),  32'(0));
        reset = 1'b1;

        // First edge after release grants port 0; f001 + 0001
        run_xact(1'b0, "add0");

        // Carry out of port 1, then result must hold through idle
        pend[1] = 1'b1;
        av[1]   = 16'hffff;
        bv[1]   = 16'h0001;
        opv[1]  = 2'b00;
        run_xact(1'b0, "carry1");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold", "result", 32'(result), 32'(16'h0000));
            chk("hold", "carry",  32'(carry),  32'(1));
            chk("hold", "busy",   32'(busy),   32'(0));
        end

        // Contention: both held, grants alternate 0,1,0,1 three cycles apart
        pend[0] = 1'b1; av[0] = 16'h1111; bv[0] = 16'h2222; opv[0] = 2'b00;
        pend[1] = 1'b1; av[1] = 16'h8000; bv[1] = 16'h8001; opv[1] = 2'b00;
        for (int i = 0; i < 4; i++) run_xact(1'b1, "contend");
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        drive();
        tick();
        chk_quiet("drop");

        // Operand isolation: a0 changes to 1234 and req0 drops during EXEC
        pend[0] = 1'b1; av[0] = 16'h0f0f; bv[0] = 16'h00f1; opv[0] = 2'b00;
        run_xact(1'b0, "isolate");

        // Reset during EXEC discards the operation
        pend[1] = 1'b1; av[1] = 16'h7fff; bv[1] = 16'h0001; opv[1] = 2'b00;
        drive();
        tick();
        chk("midrst", "gnt1", 32'(gnt1), 32'(1));
        reset = 1'b0;
        #1;
        chk_quiet("midrst_async");
        chk("midrst_async", "result", 32'(result), 32'(0));
        tick();
        chk_quiet("midrst");
        chk("midrst", "result", 32'(result), 32'(0));
        chk("midrst", "carry",  32'(carry),  32'(0));
        reset = 1'b1;
        model_last = 1;
        run_xact(1'b0, "post_rst");

        // Randomized requests and operands against the model
        for (int n = 0; n < 40; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom_range(0, 1) == 1)) begin
                    pend[p] = 1'b1;
                    av[p]   = W'($urandom);
                    bv[p]   = W'($urandom);
                    opv[p]  = 2'b00;
                end
            end
            if (!pend[0] && !pend[1]) begin
                int p;
                p       = int'($urandom_range(0, 1));
                pend[p] = 1'b1;
                av[p]   = W'($urandom);
                bv[p]   = W'($urandom);
                opv[p]  = 2'b00;
            end
            run_xact(1'b0, "rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
